cdc_pulse_feeder: RTL and testbench

Source-domain front end for the pulse-data CDC bridge. It buffers words arriving on a valid/ready stream in a small FIFO. It issues them one at a time as single-cycle s_vld/s_din pulses, and it honours the bridge's active flag so that no word is offered while a transfer is still in flight. It sits in the bridge's source clock domain, directly upstream of the bridge's s_din/s_vld/active interface.

---
 rtl/cdc_pulse_feeder.sv | 170 +++++++++++++++++
 tb/tb_cdc_pulse_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_pulse_feeder.sv
// Source-domain feeder for the pulse-data CDC bridge.
// Buffers a valid/ready input stream in a small FIFO and offers one word at a
// time to the bridge as a single-cycle out_vld/out_din pulse. A new word is
// offered only when the bridge reports no transfer in flight (br_active low).
// If the bridge never acknowledges an offered word, the feeder gives up after
// TO cycles and raises a sticky err_to flag.

module cdc_pulse_feeder #(
    parameter int unsigned DW = 8,   // data width, must match the bridge
    parameter int unsigned AW = 2,   // FIFO address width, depth = 2**AW
    parameter int unsigned TO = 15   // WAIT_HI timeout in cycles, 1..255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    output logic          in_rdy,
    output logic [DW-1:0] out_din,
    output logic          out_vld,
    input  logic          br_active,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          err_to,
    input  logic          err_clr
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [7:0]  ToCnt = 8'(TO);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitHi = 2'd1,
        StWaitLo = 2'd2
    } state_e;

    // FSM state
    state_e state_q, state_d;

    // FIFO: pointers carry one extra wrap bit to separate full from empty
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [Depth];
    logic [DW-1:0] head;

    // Bridge-side registered outputs
    logic [DW-1:0] out_din_q, out_din_d;
    logic          out_vld_q, out_vld_d;

    // Timeout bookkeeping
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;

    // Decoded control
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;
    logic          cnt_hit;
    logic          timeout;

    // FIFO status and handshake decode
    always_comb begin
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty   = (wptr_q == rptr_q);
        push    = in_vld && !full;
        head    = mem_q[rptr_q[AW-1:0]];
        // Only offer a word when idle and the bridge is not still busy
        issue   = (state_q == StIdle) && !empty && !br_active;
        cnt_hit = (cnt_q == ToCnt);
        timeout = (state_q == StWaitHi) && !br_active && cnt_hit;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: offer, wait for active to rise, wait for it to fall
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (br_active) begin
                    state_d = StWaitLo;
                end else if (cnt_hit) begin
                    // Bridge never picked the word up; drop it and move on
                    state_d = StIdle;
                end
            end
            StWaitLo: begin
                if (!br_active) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and datapath next-state: pulse, data hold, counter, error flag
    always_comb begin
        out_vld_d = issue;
        out_din_d = issue ? head : out_din_q;

        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = '0;
        end else if ((state_q == StWaitHi) && !br_active && !cnt_hit) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Setting wins over a simultaneous clear
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, issue};
    end

    // Control and output registers; reset discards FIFO contents via pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_din_q <= '0;
            out_vld_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_din_q <= out_din_d;
            out_vld_q <= out_vld_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= in_data;
        end
    end

    // Port outputs
    always_comb begin
        in_rdy  = !full;
        out_din = out_din_q;
        out_vld = out_vld_q;
        level   = wptr_q - rptr_q;
        busy    = (state_q != StIdle) || (level != '0);
        err_to  = err_q;
    end

endmodule

// File: tb/tb_cdc_pulse_feeder.sv
// Self-checking bench for cdc_pulse_feeder: a per-cycle vector table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.

module tb_cdc_pulse_feeder;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int TO    = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] out_din;
    logic          out_vld;
    logic          br_active;
    logic [AW:0]   level;
    logic          busy;
    logic          err_to;
    logic          err_clr;

    cdc_pulse_feeder #(.DW(DW), .AW(AW), .TO(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_din   (out_din),
        .out_vld   (out_vld),
        .br_active (br_active),
        .level     (level),
        .busy      (busy),
        .err_to    (err_to),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] src_q[$];

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       act;
        logic       clr;
        logic       ov;
        logic [7:0] od;
        logic [2:0] lvl;
        logic       rdy;
        logic       bsy;
        logic       err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic act,
                                input logic clr, input logic ov, input logic [7:0] od,
                                input logic [2:0] lvl, input logic rdy, input logic bsy,
                                input logic err);
        vec_t v;
        v.iv = iv; v.id = id; v.act = act; v.clr = clr; v.ov = ov; v.od = od;
        v.lvl = lvl; v.rdy = rdy; v.bsy = bsy; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn      = 1'b0;
        in_vld    = 1'b0;
        in_data   = '0;
        br_active = 1'b0;
        err_clr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Act as the bridge for one word: wait for the pulse, check it, then hold
    // active for six cycles starting the cycle after the pulse.
    task automatic serve(input logic [7:0] exp, input int budget, input string nm);
        bit seen = 1'b0;
        int bad  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (out_vld) seen = 1'b1;
        end
        chk({nm, "_seen"}, 32'(seen), 32'(1));
        if (seen) begin
            chk({nm, "_din"}, 32'(out_din), 32'(exp));
            for (int i = 0; i < 6; i++) begin
                step();
                br_active = 1'b1;
                if (out_vld) bad++;
            end
            step();
            br_active = 1'b0;
            chk({nm, "_quiet"}, 32'(bad), 32'(0));
        end
    endtask

    // Transaction-level model run. The model keeps the queue of accepted words
    // and, for each offered word, the cycle at which the feeder may offer again
    // (one cycle after the bridge's active window has been seen low).
    task automatic engine(input int ncyc, input bit rnd, input logic [7:0] init_din,
                          output logic [7:0] fin_din);
        logic [7:0] mq[$];
        int next_free = 0, last_issue = -100, win_s = 0, win_e = -1, len;
        bit exp_vld = 1'b0, accept, issue, done = 1'b0;
        logic [7:0] last_din = init_din;
        for (int c = 0; c < ncyc + 400; c++) begin
            step();
            chk("eng_vld", 32'(out_vld), 32'(exp_vld));
            chk("eng_din", 32'(out_din), 32'(last_din));
            chk("eng_level", 32'(level), 32'(mq.size()));
            chk("eng_rdy", 32'(in_rdy), 32'(mq.size() < DEPTH));
            chk("eng_busy", 32'(busy),
                32'((c > last_issue && c < next_free) || mq.size() != 0));
            chk("eng_err", 32'(err_to), 32'(0));
            if (c >= ncyc && src_q.size() == 0 && mq.size() == 0 && c >= next_free) begin
                done = 1'b1;
                break;
            end
            if (c > last_issue && c < next_free) br_active = (c >= win_s && c <= win_e);
            else if (rnd) br_active = ($urandom_range(0, 7) == 0);
            else br_active = 1'b0;
            if (src_q.size() != 0) begin
                in_vld  = 1'b1;
                in_data = src_q[0];
            end else if (rnd && c < ncyc) begin
                in_vld  = ($urandom_range(0, 1) == 1);
                in_data = 8'($urandom);
            end else begin
                in_vld = 1'b0;
            end
            accept = in_vld && (mq.size() < DEPTH);
            if (accept && src_q.size() != 0) void'(src_q.pop_front());
            issue = (c >= next_free) && (mq.size() != 0) && !br_active;
            exp_vld = issue;
            if (issue) begin
                last_din   = mq.pop_front();
                len        = rnd ? int'($urandom_range(1, 6)) : 6;
                last_issue = c;
                win_s      = c + 2;
                win_e      = c + 1 + len;
                next_free  = c + 3 + len;
            end
            if (accept) mq.push_back(in_data);
        end
        in_vld    = 1'b0;
        br_active = 1'b0;
        chk("eng_drained", 32'(done), 32'(1));
        fin_din = last_din;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fin;
        int bad;
        bit seen;

        // --- Vector table: single words, skew hold, no-op clear -------------
        //       iv  id     act clr ov  od     lvl rdy bsy err
        vt.push_back(mk(1, 8'hA5, 0, 0, 0, 8'h00, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 8'hA5, 0, 1, 1, 0));
        for (int i = 0; i < 6; i++) vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 1, 0));
        vt.push_back(mk(1, 8'h3C, 1, 0, 0, 8'hA5, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'hA5, 1, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'hA5, 1, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 8'h3C, 0, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h3C, 0, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h3C, 0, 1, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 1, 0, 8'h3C, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h3C, 0, 1, 0, 0));

        rstn = 1'b0; in_vld = 1'b0; in_data = '0; br_active = 1'b0; err_clr = 1'b0;
        #3;
        chk("rst_vld", 32'(out_vld), 32'(0));
        chk("rst_din", 32'(out_din), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_rdy", 32'(in_rdy), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err_to), 32'(0));
        reset_dut();

        foreach (vt[k]) begin
            step();
            in_vld = vt[k].iv; in_data = vt[k].id; br_active = vt[k].act; err_clr = vt[k].clr;
            chk($sformatf("vec%0d_vld", k), 32'(out_vld), 32'(vt[k].ov));
            chk($sformatf("vec%0d_din", k), 32'(out_din), 32'(vt[k].od));
            chk($sformatf("vec%0d_lvl", k), 32'(level), 32'(vt[k].lvl));
            chk($sformatf("vec%0d_rdy", k), 32'(in_rdy), 32'(vt[k].rdy));
            chk($sformatf("vec%0d_bsy", k), 32'(busy), 32'(vt[k].bsy));
            chk($sformatf("vec%0d_err", k), 32'(err_to), 32'(vt[k].err));
        end
        err_clr = 1'b0;

        // --- Burst to full while the bridge holds active, then drain --------
        reset_dut();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            br_active = 1'b1; in_vld = 1'b1; in_data = 8'(i + 1);
            if (out_vld) bad++;
        end
        step();
        in_data = 8'h99;
        chk("burst_full_rdy", 32'(in_rdy), 32'(0));
        chk("burst_full_lvl", 32'(level), 32'(4));
        step();
        in_vld = 1'b0;
        chk("burst_reject_lvl", 32'(level), 32'(4));
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_vld) bad++;
        end
        chk("hold_no_pulse", 32'(bad), 32'(0));
        step();
        br_active = 1'b0;
        serve(8'h01, 2, "burst_w1");
        serve(8'h02, 4, "burst_w2");
        serve(8'h03, 4, "burst_w3");
        serve(8'h04, 4, "burst_w4");
        step();
        chk("burst_end_lvl", 32'(level), 32'(0));
        chk("burst_end_busy", 32'(busy), 32'(0));

        // --- Push and pop in the same cycle at level 2, then 8 words over wrap
        reset_dut();
        step(); br_active = 1'b1; in_vld = 1'b1; in_data = 8'h10;
        step(); in_data = 8'h11;
        step(); in_data = 8'h12; br_active = 1'b0;
        chk("pp_lvl_pre", 32'(level), 32'(2));
        step(); in_vld = 1'b0;
        chk("pp_lvl", 32'(level), 32'(2));
        chk("pp_vld", 32'(out_vld), 32'(1));
        chk("pp_din", 32'(out_din), 32'(8'h10));
        for (int i = 0; i < 6; i++) begin step(); br_active = 1'b1; end
        step(); br_active = 1'b0;
        serve(8'h11, 4, "pp_w2");
        serve(8'h12, 4, "pp_w3");
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h20 + i));
        engine(0, 1'b0, 8'h12, fin);

        // --- Randomized traffic with random bridge windows and skew ---------
        engine(300, 1'b1, fin, fin);

        // --- Timeout, clear, and set-over-clear priority --------------------
        reset_dut();
        step(); in_vld = 1'b1; in_data = 8'h77;
        step(); in_vld = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin step(); if (out_vld) seen = 1'b1; end
        chk("to_pulse", 32'(seen), 32'(1));
        repeat (15) step();
        chk("to_early_err", 32'(err_to), 32'(0));
        chk("to_early_busy", 32'(busy), 32'(1));
        step();
        chk("to_err", 32'(err_to), 32'(1));
        chk("to_idle_busy", 32'(busy), 32'(0));
        chk("to_lost_lvl", 32'(level), 32'(0));
        step(); err_clr = 1'b1;
        step(); err_clr = 1'b0;
        chk("to_clr", 32'(err_to), 32'(0));
        step(); in_vld = 1'b1; in_data = 8'h78;
        step(); in_vld = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin step(); if (out_vld) seen = 1'b1; end
        chk("to2_pulse", 32'(seen), 32'(1));
        err_clr = 1'b1;
        repeat (15) step();
        chk("to2_early_err", 32'(err_to), 32'(0));
        step();
        chk("to2_set_wins", 32'(err_to), 32'(1));
        err_clr = 1'b0;
        step();
        chk("to2_sticky", 32'(err_to), 32'(1));

        // --- Asynchronous reset during WAIT_LO with three words queued ------
        reset_dut();
        step(); in_vld = 1'b1; in_data = 8'hB1;
        step(); in_data = 8'hB2;
        step(); in_data = 8'hB3;
        step(); in_data = 8'hB4; br_active = 1'b1;
        step(); in_vld = 1'b0;
        chk("mrst_pre_lvl", 32'(level), 32'(3));
        #2 rstn = 1'b0;
        #1;
        chk("mrst_vld", 32'(out_vld), 32'(0));
        chk("mrst_din", 32'(out_din), 32'(0));
        chk("mrst_lvl", 32'(level), 32'(0));
        chk("mrst_rdy", 32'(in_rdy), 32'(1));
        chk("mrst_busy", 32'(busy), 32'(0));
        br_active = 1'b0;
        @(negedge clk); rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin step(); if (out_vld) bad++; end
        chk("mrst_no_pulse", 32'(bad), 32'(0));
        step(); in_vld = 1'b1; in_data = 8'h5A;
        step(); in_vld = 1'b0;
        serve(8'h5A, 3, "mrst_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
